mux16_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for a shared 16-input, W-bit select path built from a 16:1 mux.
- Accepts up to 16 request lines and grants exactly one requester at a time.
- Holds the grant until the owner signals done, drops its request, or a hold timeout expires.
- Drives the registered 4-bit select for the mux, so the mux output is stable for the whole tenure.

---
 rtl/mux16_rr_arbiter.sv | 119 +++++++++++
 tb/tb_mux16_rr_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter that sequences 16 requesters onto a shared 16:1 mux.
// One tenure at a time, ended by Done, a dropped request or a hold timeout.
module mux16_rr_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] Req,
    input  logic [15:0] Mask,
    input  logic        Done,
    output logic [15:0] Grant,
    output logic [3:0]  Sel,
    output logic        Valid,
    output logic        Timeout
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    state_t            state_q, state_d;
    logic [3:0]        ptr_q, ptr_d;
    logic [3:0]        sel_q, sel_d;
    logic [15:0]       grant_q, grant_d;
    logic              valid_q, valid_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [15:0]       eligible;
    logic [15:0]       rot;
    logic [3:0]        offset;
    logic              found;
    logic [3:0]        winner;
    logic              hold_hit;
    logic              release_now;

    assign eligible = Req & ~Mask;

    // rot[0] is the source at the pointer, so the lowest set bit is the winner.
    for (genvar gi = 0; gi < 16; gi++) begin : g_rot
        assign rot[gi] = eligible[ptr_q + 4'(gi)];
    end

    always_comb begin
        found  = 1'b0;
        offset = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (rot[i]) begin
                found  = 1'b1;
                offset = 4'(i);
            end
        end
    end

    assign winner      = ptr_q + offset;
    assign hold_hit    = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST);
    assign release_now = Done || !Req[sel_q] || hold_hit;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        grant_d   = grant_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = 16'b1 << winner;
                    sel_d   = winner;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (release_now) begin
                    grant_d   = '0;
                    valid_d   = 1'b0;
                    ptr_d     = sel_q + 4'd1;
                    // Done and abandon outrank the timeout, so only a pure timeout pulses
                    timeout_d = !Done && Req[sel_q] && hold_hit;
                    state_d   = IDLE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            sel_q     <= '0;
            grant_q   <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            grant_q   <= grant_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    assign Grant   = grant_q;
    assign Sel     = sel_q;
    assign Valid   = valid_q;
    assign Timeout = timeout_q;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Directed bench for mux16_rr_arbiter: a vector table for single-cycle behaviour
// plus hand-written sequences for rotation, hold timeout and asynchronous reset.
module tb_mux16_rr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [15:0] Req;
    logic [15:0] Mask;
    logic        Done;
    logic [15:0] Grant;
    logic [3:0]  Sel;
    logic        Valid;
    logic        Timeout;

    int checks = 0;
    int errors = 0;

    mux16_rr_arbiter #(.MAX_HOLD(16), .CNT_W(5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .Req     (Req),
        .Mask    (Mask),
        .Done    (Done),
        .Grant   (Grant),
        .Sel     (Sel),
        .Valid   (Valid),
        .Timeout (Timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] req;
        logic [15:0] mask;
        logic        done;
        logic [15:0] grant;
        logic [3:0]  sel;
        logic        valid;
        logic        tout;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [15:0] eg, input logic [3:0] es,
                         input logic ev, input logic et);
        $display("%s: grant=%h sel=%0d valid=%b timeout=%b", name, Grant, Sel, Valid, Timeout);
        checks++;
        if (Grant !== eg) begin
            errors++;
            $display("FAIL %s grant: got %h want %h", name, Grant, eg);
        end
        checks++;
        if (Sel !== es) begin
            errors++;
            $display("FAIL %s sel: got %0d want %0d", name, Sel, es);
        end
        checks++;
        if (Valid !== ev) begin
            errors++;
            $display("FAIL %s valid: got %b want %b", name, Valid, ev);
        end
        checks++;
        if (Timeout !== et) begin
            errors++;
            $display("FAIL %s timeout: got %b want %b", name, Timeout, et);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs sampled at the same point.
    task automatic step(input logic [15:0] r, input logic [15:0] m, input logic d);
        Req  = r;
        Mask = m;
        Done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0;
        Req   = '0;
        Mask  = '0;
        Done  = 1'b0;
        #2;
        check(name, 16'h0000, 4'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //                req       mask      done  grant     sel    valid tout
        vecs[0]  = '{16'h0001, 16'h0000, 1'b0, 16'h0001, 4'd0,  1'b1, 1'b0};
        vecs[1]  = '{16'h0001, 16'h0000, 1'b0, 16'h0001, 4'd0,  1'b1, 1'b0};
        vecs[2]  = '{16'h0001, 16'h0000, 1'b0, 16'h0001, 4'd0,  1'b1, 1'b0};
        vecs[3]  = '{16'h0001, 16'h0000, 1'b1, 16'h0000, 4'd0,  1'b0, 1'b0};
        vecs[4]  = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 4'd0,  1'b0, 1'b0};
        vecs[5]  = '{16'h4000, 16'h0000, 1'b0, 16'h4000, 4'd14, 1'b1, 1'b0};
        vecs[6]  = '{16'h4000, 16'h0000, 1'b1, 16'h0000, 4'd14, 1'b0, 1'b0};
        vecs[7]  = '{16'h8001, 16'h0000, 1'b0, 16'h8000, 4'd15, 1'b1, 1'b0};
        vecs[8]  = '{16'h8001, 16'h0000, 1'b1, 16'h0000, 4'd15, 1'b0, 1'b0};
        vecs[9]  = '{16'h8001, 16'h0000, 1'b0, 16'h0001, 4'd0,  1'b1, 1'b0};
        vecs[10] = '{16'h8001, 16'h0000, 1'b1, 16'h0000, 4'd0,  1'b0, 1'b0};
        vecs[11] = '{16'h0006, 16'h0002, 1'b0, 16'h0004, 4'd2,  1'b1, 1'b0};
        vecs[12] = '{16'h0006, 16'h0000, 1'b0, 16'h0004, 4'd2,  1'b1, 1'b0};
        vecs[13] = '{16'h0002, 16'h0000, 1'b0, 16'h0000, 4'd2,  1'b0, 1'b0};
        vecs[14] = '{16'h0002, 16'h0000, 1'b0, 16'h0002, 4'd1,  1'b1, 1'b0};
        vecs[15] = '{16'h0002, 16'h0000, 1'b1, 16'h0000, 4'd1,  1'b0, 1'b0};
        vecs[16] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 4'd1,  1'b0, 1'b0};
        vecs[17] = '{16'h0100, 16'h0100, 1'b0, 16'h0000, 4'd1,  1'b0, 1'b0};

        rst_n = 1'b0;
        Req   = '0;
        Mask  = '0;
        Done  = 1'b0;
        #1;
        do_reset("reset0");

        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].req, vecs[i].mask, vecs[i].done);
            check($sformatf("vec%0d", i), vecs[i].grant, vecs[i].sel, vecs[i].valid, vecs[i].tout);
        end

        // Full rotation with every source requesting, ending back at source 0.
        do_reset("reset_rot");
        for (int k = 0; k < 17; k++) begin
            step(16'hFFFF, 16'h0000, 1'b0);
            check($sformatf("rot_grant%0d", k), 16'h0001 << (k % 16), 4'(k % 16), 1'b1, 1'b0);
            step(16'hFFFF, 16'h0000, 1'b1);
            check($sformatf("rot_idle%0d", k), 16'h0000, 4'(k % 16), 1'b0, 1'b0);
        end

        // Hold timeout: 16 valid cycles, Timeout with Valid falling, re-grant after one idle.
        do_reset("reset_to");
        for (int k = 0; k < 16; k++) begin
            step(16'h0010, 16'h0000, 1'b0);
            check($sformatf("to_hold%0d", k), 16'h0010, 4'd4, 1'b1, 1'b0);
        end
        step(16'h0010, 16'h0000, 1'b0);
        check("to_expire", 16'h0000, 4'd4, 1'b0, 1'b1);
        step(16'h0010, 16'h0000, 1'b0);
        check("to_regrant", 16'h0010, 4'd4, 1'b1, 1'b0);
        for (int k = 1; k < 16; k++) begin
            step(16'h0010, 16'h0000, 1'b0);
            check($sformatf("to_hold2_%0d", k), 16'h0010, 4'd4, 1'b1, 1'b0);
        end
        // Done on the last allowed cycle wins over the timeout.
        step(16'h0010, 16'h0000, 1'b1);
        check("to_done_wins", 16'h0000, 4'd4, 1'b0, 1'b0);
        step(16'h0000, 16'h0000, 1'b0);
        check("to_quiet", 16'h0000, 4'd4, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a tenure, then re-grant from Ptr=0.
        step(16'h0080, 16'h0000, 1'b0);
        check("ar_grant", 16'h0080, 4'd7, 1'b1, 1'b0);
        step(16'h0080, 16'h0000, 1'b0);
        check("ar_busy", 16'h0080, 4'd7, 1'b1, 1'b0);
        rst_n = 1'b0;
        #2;
        check("ar_async", 16'h0000, 4'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("ar_held", 16'h0000, 4'd0, 1'b0, 1'b0);
        #3;
        rst_n = 1'b1;
        step(16'h0081, 16'h0000, 1'b0);
        check("ar_from_ptr0", 16'h0001, 4'd0, 1'b1, 1'b0);
        step(16'h0081, 16'h0000, 1'b1);
        check("ar_release", 16'h0000, 4'd0, 1'b0, 1'b0);
        step(16'h0080, 16'h0000, 1'b0);
        check("ar_regrant7", 16'h0080, 4'd7, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
